// File: rtl/mem_sys_pkg.sv
// Shared sizing, FSM state type and the fixed main-memory contents for mem_sys_top.
package mem_sys_pkg;
  localparam int ADDR_W      = 8;
  localparam int LINES       = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int MISS_LAT    = 4;

  localparam int OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int CNT_W    = $clog2(MISS_LAT + 1);

  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

  typedef enum logic {
    LOOKUP,
    FILL
  } state_e;

  // ROM contents: byte at address a is (3*a + 1) mod 256.
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return 8'((16'(a) * 16'd3) + 16'd1);
  endfunction
endpackage

// File: rtl/mem_sys_cache.sv
// Direct-mapped cache storage: valid/tag/data arrays, combinational lookup, whole-block write.
// Only valid bits are reset; stale tag/data behind a cleared valid bit are never observed.
module mem_sys_cache
  import mem_sys_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               hit_o,
  output block_t             rd_line_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  block_t             wr_data_i
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  block_t           data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_line_o = data_q[rd_index_i];
endmodule

// File: rtl/mem_sys_top.sv
// Self-driving memory system: sequential address generator reading through a direct-mapped
// cache backed by a ROM with a MISS_LAT-cycle fill. Hit pulses for each cache-served read.
module mem_sys_top
  import mem_sys_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  output logic       Hit,
  output logic [7:0] MemSysOut
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic [7:0]        out_q, out_d;

  logic   cache_hit;
  block_t rd_line;
  block_t fill_data;
  logic   fill_done;
  logic   fill_we;

  wire [OFFSET_W-1:0] offset = addr_q[OFFSET_W-1:0];
  wire [INDEX_W-1:0]  index  = addr_q[OFFSET_W +: INDEX_W];
  wire [TAG_W-1:0]    tag    = addr_q[ADDR_W-1 -: TAG_W];

  mem_sys_cache u_cache (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .rd_index_i (index),
    .rd_tag_i   (tag),
    .hit_o      (cache_hit),
    .rd_line_o  (rd_line),
    .wr_en_i    (fill_we),
    .wr_index_i (index),
    .wr_tag_i   (tag),
    .wr_data_i  (fill_data)
  );

  always_comb begin
    fill_data = '0;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      fill_data[b] = mem_byte({addr_q[ADDR_W-1:OFFSET_W], b[OFFSET_W-1:0]});
    end
  end

  // A Reset landing mid-fill must leave the line untouched.
  assign fill_we = fill_done && !Reset;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    out_d     = out_q;
    fill_done = 1'b0;
    unique case (state_q)
      LOOKUP: begin
        if (cache_hit) begin
          hit_d  = 1'b1;
          out_d  = rd_line[offset];
          addr_d = addr_q + 1'b1;
        end else begin
          cnt_d   = CNT_W'(MISS_LAT);
          state_d = FILL;
        end
      end
      FILL: begin
        if (cnt_q == CNT_W'(1)) begin
          fill_done = 1'b1;
          out_d     = mem_byte(addr_q);
          addr_d    = addr_q + 1'b1;
          cnt_d     = '0;
          state_d   = LOOKUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= LOOKUP;
      addr_q  <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      out_q   <= out_d;
    end
  end

  assign Hit       = hit_q;
  assign MemSysOut = out_q;
endmodule

// File: tb/tb_mem_sys_top.sv
// Bench for mem_sys_top: directed scenarios plus randomized reset points against a read-level model.
module tb_mem_sys_top;
  localparam int M_LAT = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Hit;
  logic [7:0] MemSysOut;

  mem_sys_top dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Hit       (Hit),
    .MemSysOut (MemSysOut)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // Model: per read, either one hit edge or (1 + M_LAT) miss edges ending in the data.
  bit         mvalid [8];
  int         mtag   [8];
  int         maddr;
  int         mlast;
  logic [8:0] expq [$];

  function automatic int mem(input int a);
    return (3 * a + 1) % 256;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 0;
    end
    maddr = 0;
    mlast = 0;
    expq.delete();
  endfunction

  function automatic void model_next(output logic eh, output logic [7:0] ed);
    logic [8:0] e;
    if (expq.size() == 0) begin
      int idx, tg;
      idx = (maddr / 4) % 8;
      tg  = maddr / 32;
      if (mvalid[idx] && mtag[idx] == tg) begin
        expq.push_back({1'b1, 8'(mem(maddr))});
      end else begin
        for (int k = 0; k < M_LAT; k++) expq.push_back({1'b0, 8'(mlast)});
        expq.push_back({1'b0, 8'(mem(maddr))});
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
      mlast = mem(maddr);
      maddr = (maddr + 1) % 256;
    end
    e  = expq.pop_front();
    eh = e[8];
    ed = e[7:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [7:0] exp_d [4] = '{8'd1, 8'd4, 8'd7, 8'd10};
    Reset = 1'b1;
    tick();
    tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=0", Hit, MemSysOut);
    end
    Reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e >= 5) begin
        tests++;
        if (Hit !== (e > 5) || MemSysOut !== exp_d[e-5]) begin
          fails++;
          $display("FAIL first_block edge%0d: Hit=%b MemSysOut=%0d, want Hit=%b MemSysOut=%0d",
                   e, Hit, MemSysOut, (e > 5), exp_d[e-5]);
        end
      end
    end
  endtask

  task automatic test_hit_rate();
    int hits = 0;
    int xs = 0;
    do_reset();
    tick();
    for (int e = 0; e < 100; e++) begin
      tick();
      if ($isunknown(Hit)) xs++;
      else if (Hit) hits++;
    end
    tests++;
    if (xs != 0) begin
      fails++;
      $display("FAIL hit_x: Hit unknown on %0d edges, want 0", xs);
    end
    tests++;
    if (hits != 36) begin
      fails++;
      $display("FAIL hit_rate: hits=%0d, want 36", hits);
    end
  endtask

  task automatic test_block_boundary();
    logic [7:0] exp_d [3] = '{8'd16, 8'd19, 8'd22};
    do_reset();
    repeat (8) tick();
    tests++;
    if (Hit !== 1'b1 || MemSysOut !== 8'd10) begin
      fails++;
      $display("FAIL addr3_done: Hit=%b MemSysOut=%0d, want Hit=1 MemSysOut=10", Hit, MemSysOut);
    end
    tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd10) begin
      fails++;
      $display("FAIL block1_miss: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=10", Hit, MemSysOut);
    end
    repeat (4) tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd13) begin
      fails++;
      $display("FAIL block1_fill: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=13", Hit, MemSysOut);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (Hit !== 1'b1 || MemSysOut !== exp_d[i]) begin
        fails++;
        $display("FAIL block1_hit%0d: Hit=%b MemSysOut=%0d, want Hit=1 MemSysOut=%0d",
                 i, Hit, MemSysOut, exp_d[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (512) tick();
    tests++;
    if (Hit !== 1'b1 || MemSysOut !== 8'd254) begin
      fails++;
      $display("FAIL addr255: Hit=%b MemSysOut=%0d, want Hit=1 MemSysOut=254", Hit, MemSysOut);
    end
    tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd254) begin
      fails++;
      $display("FAIL wrap_miss: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=254", Hit, MemSysOut);
    end
    repeat (4) tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd1) begin
      fails++;
      $display("FAIL wrap_fill: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=1", Hit, MemSysOut);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic       eh;
    logic [7:0] ed;
    do_reset();
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    tests++;
    if (Hit !== 1'b0 || MemSysOut !== 8'd0) begin
      fails++;
      $display("FAIL midfill_reset: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=0", Hit, MemSysOut);
    end
    Reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 16; e++) begin
      tick();
      model_next(eh, ed);
      tests++;
      if (Hit !== eh || MemSysOut !== ed) begin
        fails++;
        $display("FAIL midfill_restart edge%0d: Hit=%b MemSysOut=%0d, want Hit=%b MemSysOut=%0d",
                 e, Hit, MemSysOut, eh, ed);
      end
    end
  endtask

  task automatic test_random_resets();
    logic       eh;
    logic [7:0] ed;
    int         n;
    int         bad;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 200);
      bad = 0;
      for (int e = 0; e < n; e++) begin
        tick();
        model_next(eh, ed);
        if (Hit !== eh || MemSysOut !== ed) begin
          if (bad == 0)
            $display("FAIL random_run%0d edge%0d: Hit=%b MemSysOut=%0d, want Hit=%b MemSysOut=%0d",
                     it, e + 1, Hit, MemSysOut, eh, ed);
          bad++;
        end
      end
      tests++;
      if (bad != 0) fails++;
      Reset = 1'b1;
      tick();
      tests++;
      if (Hit !== 1'b0 || MemSysOut !== 8'd0) begin
        fails++;
        $display("FAIL random_reset%0d: Hit=%b MemSysOut=%0d, want Hit=0 MemSysOut=0",
                 it, Hit, MemSysOut);
      end
      Reset = 1'b0;
      model_reset();
    end
  endtask

  initial begin
    test_reset();
    test_hit_rate();
    test_block_boundary();
    test_wrap();
    test_reset_mid_fill();
    test_random_resets();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
